// File: rtl/spi_minion_arbiter.sv
// spi_minion_arbiter: shares one SPI minion adapter between num_reqs endpoints.
// Downstream path: round-robin arbiter that tags each endpoint message with its
// source ID in the MSBs. Upstream path: router that delivers adapter messages to
// the endpoint named by the MSB tag. Each path has a single registered entry.
// Optional feature: define SPI_ARB_ERR_CNT_EN to get a saturating misroute
// counter on err_count; without it err_count is tied to zero.
module spi_minion_arbiter #(
  parameter int msg_nbits = 6,
  parameter int num_reqs  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [msg_nbits-1:0]   adp_send_msg,
  input  logic                   adp_send_val,
  output logic                   adp_send_rdy,
  output logic [msg_nbits-1:0]   adp_recv_msg,
  output logic                   adp_recv_val,
  input  logic                   adp_recv_rdy,
  input  logic [num_reqs*(msg_nbits-$clog2(num_reqs))-1:0] req_msg,
  input  logic [num_reqs-1:0]    req_val,
  output logic [num_reqs-1:0]    req_rdy,
  output logic [msg_nbits-$clog2(num_reqs)-1:0] resp_msg,
  output logic [num_reqs-1:0]    resp_val,
  input  logic [num_reqs-1:0]    resp_rdy,
  output logic [7:0]             err_count
);

  localparam int an = $clog2(num_reqs);
  localparam int dw = msg_nbits - an;
  localparam logic [an:0]   num_wide = (an+1)'(num_reqs);
  localparam logic [an-1:0] last_id  = an'(num_reqs - 1);

  // ---------------- arbiter state (endpoints -> adapter) ----------------
  logic                 or_full;
  logic [msg_nbits-1:0] or_msg;
  logic [an-1:0]        ptr;
  logic                 can_load;
  logic                 grant_found;
  logic [an-1:0]        grant_idx;
  logic [an:0]          scan_idx;
  logic [an-1:0]        scan_lo;
  logic [dw-1:0]        grant_data;

  // ---------------- router state (adapter -> endpoints) -----------------
  logic                 rr_full;
  logic [an-1:0]        rr_dst;
  logic [dw-1:0]        rr_data;
  logic                 drain;
  logic                 send_fire;
  logic [an-1:0]        send_tag;
  logic                 tag_ok;

  assign can_load = !or_full || adp_recv_rdy;

  // Round-robin search starting at ptr; nothing is granted during reset or when
  // the output register cannot accept a new entry.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    scan_lo     = '0;
    if (!reset && can_load) begin
      for (int i = 0; i < num_reqs; i++) begin
        scan_idx = {1'b0, ptr} + (an+1)'(i);
        if (scan_idx >= num_wide)
          scan_idx = scan_idx - num_wide;
        scan_lo = scan_idx[an-1:0];
        if (!grant_found && req_val[scan_lo]) begin
          grant_found = 1'b1;
          grant_idx   = scan_lo;
        end
      end
    end
  end

  assign grant_data = req_msg[grant_idx*dw +: dw];

  // One-hot ready to the granted endpoint.
  always_comb begin
    req_rdy = '0;
    if (grant_found)
      req_rdy[grant_idx] = 1'b1;
  end

  // Output register: load the tagged winner, otherwise empty once it drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      or_full <= 1'b0;
      or_msg  <= '0;
      ptr     <= '0;
    end else if (grant_found) begin
      or_full <= 1'b1;
      or_msg  <= {grant_idx, grant_data};
      ptr     <= (grant_idx == last_id) ? '0 : grant_idx + 1'b1;
    end else if (adp_recv_rdy) begin
      or_full <= 1'b0;
    end
  end

  assign adp_recv_val = or_full;
  assign adp_recv_msg = or_msg;

  // ---------------- router ----------------
  assign drain        = rr_full && resp_rdy[rr_dst];
  assign adp_send_rdy = !reset && (!rr_full || drain);
  assign send_fire    = adp_send_val && adp_send_rdy;
  assign send_tag     = adp_send_msg[msg_nbits-1 -: an];
  assign tag_ok       = ({1'b0, send_tag} < num_wide);

  // Route register: accept in-range messages, drop misrouted ones, and empty
  // when the addressed endpoint takes the current entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_full <= 1'b0;
      rr_dst  <= '0;
      rr_data <= '0;
    end else if (send_fire && tag_ok) begin
      rr_full <= 1'b1;
      rr_dst  <= send_tag;
      rr_data <= adp_send_msg[dw-1:0];
    end else if (drain) begin
      rr_full <= 1'b0;
    end
  end

  // Decode the held destination into a one-hot valid.
  always_comb begin
    resp_val = '0;
    if (rr_full)
      resp_val[rr_dst] = 1'b1;
  end

  assign resp_msg = rr_data;

`ifdef SPI_ARB_ERR_CNT_EN
  logic       misroute;
  logic [7:0] err_q;

  assign misroute = send_fire && !tag_ok;

  // Saturating count of dropped messages, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)
      err_q <= 8'd0;
    else if (misroute && err_q != 8'hFF)
      err_q <= err_q + 8'd1;
  end

  assign err_count = err_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_spi_minion_arbiter.sv
// Directed testbench for spi_minion_arbiter: a 2-endpoint instance exercises
// arbitration, backpressure, routing and mid-traffic reset; a 3-endpoint
// instance exercises rotation over three sources and misrouted tags.
module tb_spi_minion_arbiter;

`ifdef SPI_ARB_ERR_CNT_EN
  localparam bit err_en = 1'b1;
`else
  localparam bit err_en = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  // 2-endpoint instance (an=1, dw=5)
  logic [5:0] a_send_msg;
  logic       a_send_val;
  logic       a_send_rdy;
  logic [5:0] a_recv_msg;
  logic       a_recv_val;
  logic       a_recv_rdy;
  logic [9:0] a_req_msg;
  logic [1:0] a_req_val;
  logic [1:0] a_req_rdy;
  logic [4:0] a_resp_msg;
  logic [1:0] a_resp_val;
  logic [1:0] a_resp_rdy;
  logic [7:0] a_err;

  // 3-endpoint instance (an=2, dw=4)
  logic [5:0]  b_send_msg;
  logic        b_send_val;
  logic        b_send_rdy;
  logic [5:0]  b_recv_msg;
  logic        b_recv_val;
  logic        b_recv_rdy;
  logic [11:0] b_req_msg;
  logic [2:0]  b_req_val;
  logic [2:0]  b_req_rdy;
  logic [3:0]  b_resp_msg;
  logic [2:0]  b_resp_val;
  logic [2:0]  b_resp_rdy;
  logic [7:0]  b_err;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  spi_minion_arbiter #(.msg_nbits(6), .num_reqs(2)) dut_a (
    .clk(clk), .reset(reset),
    .adp_send_msg(a_send_msg), .adp_send_val(a_send_val), .adp_send_rdy(a_send_rdy),
    .adp_recv_msg(a_recv_msg), .adp_recv_val(a_recv_val), .adp_recv_rdy(a_recv_rdy),
    .req_msg(a_req_msg), .req_val(a_req_val), .req_rdy(a_req_rdy),
    .resp_msg(a_resp_msg), .resp_val(a_resp_val), .resp_rdy(a_resp_rdy),
    .err_count(a_err)
  );

  spi_minion_arbiter #(.msg_nbits(6), .num_reqs(3)) dut_b (
    .clk(clk), .reset(reset),
    .adp_send_msg(b_send_msg), .adp_send_val(b_send_val), .adp_send_rdy(b_send_rdy),
    .adp_recv_msg(b_recv_msg), .adp_recv_val(b_recv_val), .adp_recv_rdy(b_recv_rdy),
    .req_msg(b_req_msg), .req_val(b_req_val), .req_rdy(b_req_rdy),
    .resp_msg(b_resp_msg), .resp_val(b_resp_val), .resp_rdy(b_resp_rdy),
    .err_count(b_err)
  );

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the given number of clock cycles with inputs held, then settle
  // just after the edge so registered outputs are stable.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset      = 1'b1;
    a_send_msg = '0; a_send_val = 1'b0; a_recv_rdy = 1'b0;
    a_req_msg  = '0; a_req_val  = '0;   a_resp_rdy = '0;
    b_send_msg = '0; b_send_val = 1'b0; b_recv_rdy = 1'b0;
    b_req_msg  = '0; b_req_val  = '0;   b_resp_rdy = '0;

    applyStimulus(2);
    checkOutput("send_rdy_in_reset", 32'(a_send_rdy), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("rst_recv_val", 32'(a_recv_val), 32'd0);
    checkOutput("rst_resp_val", 32'(a_resp_val), 32'd0);
    checkOutput("rst_send_rdy", 32'(a_send_rdy), 32'd1);
    checkOutput("rst_err",      32'(a_err),      32'd0);
    checkOutput("rst_req_rdy",  32'(a_req_rdy),  32'd0);

    // Two endpoints always valid: rotation 0,1,0 with tag in MSB.
    a_req_msg  = {5'h15, 5'h0A};
    a_req_val  = 2'b11;
    a_recv_rdy = 1'b1;
    #1;
    checkOutput("arb_first_grant", 32'(a_req_rdy), 32'h1);
    applyStimulus(1);
    checkOutput("arb_val0", 32'(a_recv_val), 32'd1);
    checkOutput("arb_msg0", 32'(a_recv_msg), 32'h0A);
    checkOutput("arb_grant1", 32'(a_req_rdy), 32'h2);
    applyStimulus(1);
    checkOutput("arb_msg1", 32'(a_recv_msg), 32'h35);
    applyStimulus(1);
    checkOutput("arb_msg2", 32'(a_recv_msg), 32'h0A);

    // Backpressure for three cycles: entry held, no grants.
    a_recv_rdy = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_req_rdy", 32'(a_req_rdy),  32'd0);
      checkOutput("bp_msg",     32'(a_recv_msg), 32'h0A);
      checkOutput("bp_val",     32'(a_recv_val), 32'd1);
      applyStimulus(1);
    end
    a_recv_rdy = 1'b1;
    #1;
    checkOutput("bp_release_grant", 32'(a_req_rdy), 32'h2);
    applyStimulus(1);
    checkOutput("bp_release_msg", 32'(a_recv_msg), 32'h35);
    a_req_val = 2'b00;
    applyStimulus(1);
    checkOutput("arb_drain_empty", 32'(a_recv_val), 32'd0);

    // Router: tag 1, data 7, endpoint 1 not ready.
    a_send_msg = 6'h27;
    a_send_val = 1'b1;
    a_resp_rdy = 2'b00;
    #1;
    checkOutput("rt_send_rdy_idle", 32'(a_send_rdy), 32'd1);
    applyStimulus(1);
    a_send_val = 1'b0;
    #1;
    checkOutput("rt_resp_val", 32'(a_resp_val), 32'h2);
    checkOutput("rt_resp_msg", 32'(a_resp_msg), 32'h07);
    checkOutput("rt_send_rdy_full", 32'(a_send_rdy), 32'd0);
    a_resp_rdy = 2'b01;
    applyStimulus(2);
    checkOutput("rt_hold_val", 32'(a_resp_val), 32'h2);
    checkOutput("rt_hold_rdy", 32'(a_send_rdy), 32'd0);
    a_resp_rdy = 2'b10;
    #1;
    checkOutput("rt_drain_rdy", 32'(a_send_rdy), 32'd1);
    applyStimulus(1);
    checkOutput("rt_drained", 32'(a_resp_val), 32'd0);

    // Back-to-back routing: drain and load in the same cycle.
    a_resp_rdy = 2'b11;
    a_send_msg = 6'h05;
    a_send_val = 1'b1;
    applyStimulus(1);
    checkOutput("b2b_val0", 32'(a_resp_val), 32'h1);
    checkOutput("b2b_msg0", 32'(a_resp_msg), 32'h05);
    a_send_msg = 6'h2A;
    #1;
    checkOutput("b2b_rdy", 32'(a_send_rdy), 32'd1);
    applyStimulus(1);
    checkOutput("b2b_val1", 32'(a_resp_val), 32'h2);
    checkOutput("b2b_msg1", 32'(a_resp_msg), 32'h0A);
    a_send_val = 1'b0;
    applyStimulus(1);
    checkOutput("b2b_empty", 32'(a_resp_val), 32'd0);

    // Three endpoints: rotation 0,1,2,0.
    b_req_msg  = {4'h3, 4'h2, 4'h1};
    b_req_val  = 3'b111;
    b_recv_rdy = 1'b1;
    applyStimulus(1);
    checkOutput("rr3_msg0", 32'(b_recv_msg), 32'h01);
    applyStimulus(1);
    checkOutput("rr3_msg1", 32'(b_recv_msg), 32'h12);
    applyStimulus(1);
    checkOutput("rr3_msg2", 32'(b_recv_msg), 32'h23);
    applyStimulus(1);
    checkOutput("rr3_msg3", 32'(b_recv_msg), 32'h01);
    // ptr now 1; with only endpoints 0 and 2 valid the search skips to 2.
    b_req_val = 3'b101;
    #1;
    checkOutput("rr3_skip", 32'(b_req_rdy), 32'h4);
    b_req_val = 3'b000;
    applyStimulus(1);

    // Misroute on the 3-endpoint instance: tag 3 is out of range.
    b_resp_rdy = 3'b111;
    b_send_msg = 6'h3F;
    b_send_val = 1'b1;
    applyStimulus(1);
    checkOutput("mis_resp_val", 32'(b_resp_val), 32'd0);
    checkOutput("mis_send_rdy", 32'(b_send_rdy), 32'd1);
    checkOutput("mis_err1", 32'(b_err), err_en ? 32'd1 : 32'd0);
    applyStimulus(299);
    checkOutput("mis_err_sat", 32'(b_err), err_en ? 32'd255 : 32'd0);
    checkOutput("mis_rdy_after", 32'(b_send_rdy), 32'd1);
    b_send_val = 1'b0;

    // Fill both registers of the 2-endpoint instance, leaving ptr at 1.
    a_req_val  = 2'b01;
    a_recv_rdy = 1'b0;
    a_send_msg = 6'h27;
    a_send_val = 1'b1;
    a_resp_rdy = 2'b00;
    applyStimulus(1);
    a_req_val  = 2'b00;
    a_send_val = 1'b0;
    #1;
    checkOutput("pre_rst_recv_val", 32'(a_recv_val), 32'd1);
    checkOutput("pre_rst_resp_val", 32'(a_resp_val), 32'h2);
    reset     = 1'b1;
    a_req_val = 2'b11;
    #1;
    checkOutput("in_rst_req_rdy", 32'(a_req_rdy), 32'd0);
    applyStimulus(1);
    reset = 1'b0;
    a_req_val = 2'b00;
    #1;
    checkOutput("post_rst_recv_val", 32'(a_recv_val), 32'd0);
    checkOutput("post_rst_resp_val", 32'(a_resp_val), 32'd0);
    checkOutput("post_rst_err", 32'(b_err), 32'd0);
    a_req_val  = 2'b11;
    a_recv_rdy = 1'b1;
    #1;
    checkOutput("post_rst_grant", 32'(a_req_rdy), 32'h1);
    applyStimulus(1);
    checkOutput("post_rst_msg", 32'(a_recv_msg), 32'h0A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
